// File: rtl/onn_pkg.sv
// Shared definitions for the ONN image path: frame geometry and the
// receiver state encoding.
package onn_pkg;

  // 3x5 neurons, 4 bits each.
  localparam int FRAME_W = 60;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2,
    DRAIN = 2'd3
  } rx_state_t;

endpackage

// File: rtl/img_rx.sv
// Serial image receiver. Deserialises one bit per clock while load is high
// into a FRAME_W-bit pattern, rejects short and long frames, and hands good
// patterns to the ONN core through a valid/ready holding register.
module img_rx
  import onn_pkg::*;
#(
  parameter int FRAME_W = onn_pkg::FRAME_W,
  parameter int CNT_W   = $clog2(FRAME_W + 1)
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               data_in,
  input  logic               load,
  output logic [FRAME_W-1:0] img_out,
  output logic               img_valid,
  input  logic               img_ready,
  output logic               frame_err,
  output logic               overrun,
  output logic               busy,
  output logic [7:0]         frames_ok
);

  rx_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [FRAME_W-1:0] img_out_q, img_out_d;
  logic               img_valid_q, img_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         frames_ok_q, frames_ok_d;
  logic               publish_req;

  // Next-state, datapath and handshake decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    img_out_d   = img_out_q;
    img_valid_d = img_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    frames_ok_d = frames_ok_q;
    publish_req = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          // First bit ends up in bit 0 once the whole frame has shifted in.
          sr_d    = {data_in, sr_q[FRAME_W-1:1]};
          cnt_d   = CNT_W'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (load) begin
          sr_d  = {data_in, sr_q[FRAME_W-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(FRAME_W - 1)) state_d = CHECK;
        end else begin
          // Load dropped early: short frame.
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      CHECK: begin
        cnt_d = '0;
        if (load) begin
          // One bit too many: long frame, swallow the rest silently.
          frame_err_d = 1'b1;
          state_d     = DRAIN;
        end else begin
          publish_req = 1'b1;
          state_d     = IDLE;
        end
      end
      DRAIN: begin
        if (!load) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A publish may replace a pattern only if the core takes the old one now.
    if (publish_req) begin
      if (!img_valid_q || img_ready) begin
        img_out_d   = sr_q;
        img_valid_d = 1'b1;
        frames_ok_d = frames_ok_q + 8'd1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (img_valid_q && img_ready) begin
      img_valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift register is reset too, so a frame cut by reset leaves no stale bits.
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      img_out_q   <= '0;
      img_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      frames_ok_q <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      img_out_q   <= img_out_d;
      img_valid_q <= img_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      frames_ok_q <= frames_ok_d;
    end
  end

  assign img_out   = img_out_q;
  assign img_valid = img_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign frames_ok = frames_ok_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_img_rx.sv
// Directed bench for img_rx. Inputs change and outputs are sampled on the
// falling edge; the DUT acts on the rising edge.
module tb_img_rx;

  localparam int FW = 60;

  logic          sclk = 1'b0;
  logic          rst_n;
  logic          data_in;
  logic          load;
  logic [FW-1:0] img_out;
  logic          img_valid;
  logic          img_ready;
  logic          frame_err;
  logic          overrun;
  logic          busy;
  logic [7:0]    frames_ok;

  int n_total = 0;
  int n_pass  = 0;
  int err_pulses = 0;
  int ovr_pulses = 0;

  img_rx dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .load      (load),
    .img_out   (img_out),
    .img_valid (img_valid),
    .img_ready (img_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .frames_ok (frames_ok)
  );

  always #5 sclk = ~sclk;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge sclk) begin
    if (frame_err === 1'b1) err_pulses++;
    if (overrun === 1'b1) ovr_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; drives n bits (zeros past FW) and returns at
  // the falling edge after the last bit was sampled, with load still high.
  task automatic drive_bits(input logic [FW-1:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      load    = 1'b1;
      data_in = (i < FW) ? pat[i] : 1'b0;
      @(negedge sclk);
    end
  endtask

  task automatic drop_load();
    load    = 1'b0;
    data_in = 1'b0;
    @(negedge sclk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; data_in = 1'b0; img_ready = 1'b0;
    repeat (3) @(negedge sclk);
    n_total++;
    if ({img_out, img_valid, frame_err, overrun, busy, frames_ok} !== '0) begin
      $display("FAIL reset_outputs: got out=%h v=%b e=%b o=%b b=%b n=%0d, want all zero",
               img_out, img_valid, frame_err, overrun, busy, frames_ok);
    end else n_pass++;
    rst_n = 1'b1;
    @(negedge sclk);
  endtask

  task automatic test_single_frame();
    logic [FW-1:0] a = 60'h880880880880880;
    int e0 = err_pulses, o0 = ovr_pulses;
    drive_bits(a, FW);
    n_total++;
    if (img_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL single_pre_publish: got v=%b busy=%b, want v=0 busy=1", img_valid, busy);
    end else n_pass++;
    drop_load();
    n_total++;
    if (img_valid !== 1'b1 || img_out !== a) begin
      $display("FAIL single_publish: got v=%b out=%h, want v=1 out=%h", img_valid, img_out, a);
    end else n_pass++;
    n_total++;
    if (frames_ok !== 8'd1 || busy !== 1'b0) begin
      $display("FAIL single_count: got frames_ok=%0d busy=%b, want 1 and 0", frames_ok, busy);
    end else n_pass++;
    n_total++;
    if (err_pulses != e0 || ovr_pulses != o0) begin
      $display("FAIL single_no_pulses: got err=%0d ovr=%0d, want %0d %0d",
               err_pulses, ovr_pulses, e0, o0);
    end else n_pass++;
  endtask

  task automatic test_consume();
    logic [FW-1:0] held = img_out;
    img_ready = 1'b1;
    @(negedge sclk);
    img_ready = 1'b0;
    n_total++;
    if (img_valid !== 1'b0 || img_out !== 60'h880880880880880) begin
      $display("FAIL consume: got v=%b out=%h, want v=0 out=%h", img_valid, img_out, held);
    end else n_pass++;
  endtask

  task automatic test_short_frame();
    int e0 = err_pulses;
    drive_bits(60'hFFF_FFFF_FFFF_FFFF, 37);
    drop_load();
    n_total++;
    if (frame_err !== 1'b1 || busy !== 1'b0 || img_valid !== 1'b0) begin
      $display("FAIL short_frame: got err=%b busy=%b v=%b, want 1 0 0", frame_err, busy, img_valid);
    end else n_pass++;
    @(negedge sclk);
    n_total++;
    if (err_pulses != e0 + 1 || frames_ok !== 8'd1) begin
      $display("FAIL short_pulse_count: got pulses=%0d frames_ok=%0d, want %0d and 1",
               err_pulses - e0, frames_ok, 1);
    end else n_pass++;
  endtask

  task automatic test_long_frame();
    int e0 = err_pulses;
    drive_bits(60'h123456789ABCDEF, FW);
    n_total++;
    if (frame_err !== 1'b0) begin
      $display("FAIL long_no_err_at_60: got err=%b, want 0", frame_err);
    end else n_pass++;
    drive_bits('0, 1);
    n_total++;
    if (frame_err !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL long_err_at_61: got err=%b busy=%b, want 1 1", frame_err, busy);
    end else n_pass++;
    drive_bits('0, 3);
    n_total++;
    if (busy !== 1'b1 || err_pulses != e0 + 1) begin
      $display("FAIL long_drain: got busy=%b pulses=%0d, want 1 and 1", busy, err_pulses - e0);
    end else n_pass++;
    drop_load();
    n_total++;
    if (busy !== 1'b0 || img_valid !== 1'b0 || frames_ok !== 8'd1) begin
      $display("FAIL long_exit: got busy=%b v=%b frames_ok=%0d, want 0 0 1",
               busy, img_valid, frames_ok);
    end else n_pass++;
  endtask

  task automatic test_back_to_back(input logic ready_on_second);
    logic [FW-1:0] a = 60'h000080080080000;
    logic [FW-1:0] b = 60'h010080080080100;
    logic [7:0] n0 = frames_ok;
    int o0 = ovr_pulses;
    drive_bits(a, FW);
    drop_load();
    n_total++;
    if (img_valid !== 1'b1 || img_out !== a) begin
      $display("FAIL b2b_first[%0b]: got v=%b out=%h, want v=1 out=%h",
               ready_on_second, img_valid, img_out, a);
    end else n_pass++;
    drive_bits(b, FW);
    load = 1'b0; data_in = 1'b0; img_ready = ready_on_second;
    @(negedge sclk);
    img_ready = 1'b0;
    if (!ready_on_second) begin
      n_total++;
      if (overrun !== 1'b1 || img_out !== a || img_valid !== 1'b1) begin
        $display("FAIL b2b_overrun: got ovr=%b out=%h v=%b, want 1 %h 1",
                 overrun, img_out, img_valid, a);
      end else n_pass++;
      n_total++;
      if (frames_ok !== n0 + 8'd1) begin
        $display("FAIL b2b_overrun_count: got %0d, want %0d", frames_ok, n0 + 8'd1);
      end else n_pass++;
    end else begin
      n_total++;
      if (overrun !== 1'b0 || img_out !== b || img_valid !== 1'b1) begin
        $display("FAIL b2b_replace: got ovr=%b out=%h v=%b, want 0 %h 1",
                 overrun, img_out, img_valid, b);
      end else n_pass++;
      n_total++;
      if (frames_ok !== n0 + 8'd2) begin
        $display("FAIL b2b_replace_count: got %0d, want %0d", frames_ok, n0 + 8'd2);
      end else n_pass++;
    end
    @(negedge sclk);
    n_total++;
    if (ovr_pulses != o0 + (ready_on_second ? 0 : 1)) begin
      $display("FAIL b2b_overrun_pulses[%0b]: got %0d, want %0d",
               ready_on_second, ovr_pulses - o0, ready_on_second ? 0 : 1);
    end else n_pass++;
    // Empty the holding register for the next scenario.
    img_ready = 1'b1;
    @(negedge sclk);
    img_ready = 1'b0;
  endtask

  task automatic test_mid_frame_reset();
    logic [FW-1:0] c = 60'h780880880880881;
    drive_bits(c, 30);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({img_out, img_valid, frame_err, overrun, busy, frames_ok} !== '0) begin
      $display("FAIL midreset_async: got out=%h v=%b busy=%b n=%0d, want all zero",
               img_out, img_valid, busy, frames_ok);
    end else n_pass++;
    load = 1'b0; data_in = 1'b0;
    repeat (2) @(negedge sclk);
    n_total++;
    if ({img_out, img_valid, frame_err, overrun, busy, frames_ok} !== '0) begin
      $display("FAIL midreset_held: got out=%h v=%b busy=%b n=%0d, want all zero",
               img_out, img_valid, busy, frames_ok);
    end else n_pass++;
    rst_n = 1'b1;
    @(negedge sclk);
    drive_bits(c, FW);
    drop_load();
    n_total++;
    if (img_valid !== 1'b1 || img_out !== c || frames_ok !== 8'd1) begin
      $display("FAIL midreset_frame: got v=%b out=%h n=%0d, want 1 %h 1",
               img_valid, img_out, frames_ok, c);
    end else n_pass++;
  endtask

  initial begin
    @(negedge sclk);
    test_reset();
    test_single_frame();
    test_consume();
    test_short_frame();
    test_long_frame();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
